// File: rtl/bidir_buffer_ctrl_if.sv
// -----------------------------------------------------------------------------
// bidir_buffer_ctrl_if
// Signal bundle between the bidirectional-buffer controller and its
// surroundings (request source, the 8-bit buffer's CE/SR pins and its
// AOUT/BOUT outputs fed back for capture).
//
// Signals:
//   REQ_UP, REQ_DN   level requests for A->B / B->A transfers
//   BOUT_IN, AOUT_IN buffer outputs sampled back at the end of a transfer
//   CE, SR           buffer chip enable and direction (SR=1 is up)
//   BUSY, DONE       controller status and one-cycle completion pulse
//   DIR_LAST         direction of the last completed transfer
//   DATA_CAPT        data captured by the last completed transfer
//   CNT_CLR, XFER_CNT  completed-transfer counter clear/value, present only
//                      when BIDIR_XFER_CNT_EN is defined
//
// Modports:
//   master  the controller itself (drives CE/SR/status)
//   slave   the environment (drives requests and buffer data)
// -----------------------------------------------------------------------------
interface bidir_buffer_ctrl_if;
    logic       REQ_UP;
    logic       REQ_DN;
    logic [7:0] BOUT_IN;
    logic [7:0] AOUT_IN;
    logic       CE;
    logic       SR;
    logic       BUSY;
    logic       DONE;
    logic       DIR_LAST;
    logic [7:0] DATA_CAPT;
`ifdef BIDIR_XFER_CNT_EN
    logic        CNT_CLR;
    logic [15:0] XFER_CNT;

    modport master (
        input  REQ_UP, REQ_DN, BOUT_IN, AOUT_IN, CNT_CLR,
        output CE, SR, BUSY, DONE, DIR_LAST, DATA_CAPT, XFER_CNT
    );

    modport slave (
        output REQ_UP, REQ_DN, BOUT_IN, AOUT_IN, CNT_CLR,
        input  CE, SR, BUSY, DONE, DIR_LAST, DATA_CAPT, XFER_CNT
    );
`else
    modport master (
        input  REQ_UP, REQ_DN, BOUT_IN, AOUT_IN,
        output CE, SR, BUSY, DONE, DIR_LAST, DATA_CAPT
    );

    modport slave (
        output REQ_UP, REQ_DN, BOUT_IN, AOUT_IN,
        input  CE, SR, BUSY, DONE, DIR_LAST, DATA_CAPT
    );
`endif
endinterface

// File: rtl/bidir_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// bidir_buffer_ctrl
// Drives CE/SR of an 8-bit bidirectional buffer. Arbitrates up (A->B, SR=1)
// and down (B->A, SR=0) requests with a round-robin pointer when both are
// present, inserts TURN_CYCLES dead cycles (CE=0) whenever the direction
// changes, holds CE high for DRIVE_CYCLES, then latches the buffer output
// and pulses DONE for one cycle.
//
// Ports:
//   CLK  system clock, rising edge
//   RST  asynchronous active-high reset; drops CE immediately and abandons
//        any transfer in flight (no DONE)
//   bus  bidir_buffer_ctrl_if.master (requests, buffer data in, CE/SR,
//        BUSY/DONE/DIR_LAST/DATA_CAPT out)
//
// Parameters:
//   DRIVE_CYCLES  CE-high cycles per transfer, legal 1..15
//   TURN_CYCLES   CE-low dead cycles on a direction change, legal 1..7
//
// Optional feature (macro BIDIR_XFER_CNT_EN):
//   adds bus.XFER_CNT, a saturating 16-bit count of completed transfers,
//   and bus.CNT_CLR, a synchronous clear that wins over a coincident DONE.
// -----------------------------------------------------------------------------
module bidir_buffer_ctrl #(
    parameter int unsigned DRIVE_CYCLES = 2,
    parameter int unsigned TURN_CYCLES  = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    bidir_buffer_ctrl_if.master   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TURN  = 2'd1,
        ST_DRIVE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] DRV_LAST  = 4'(DRIVE_CYCLES - 1);
    localparam logic [2:0] TURN_LAST = 3'(TURN_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] drv_cnt;
    logic [3:0] drv_cnt_nxt;
    logic [2:0] turn_cnt;
    logic [2:0] turn_cnt_nxt;
    logic       sr_q;
    logic       sr_nxt;
    logic       ptr_up_q;      // 1: next contested grant goes up
    logic       ptr_up_nxt;
    logic       dir_last_q;
    logic       dir_last_nxt;
    logic [7:0] data_q;
    logic [7:0] data_nxt;

    logic       req_any;
    logic       req_both;
    logic       grant_up;
    logic       arb_en;

    // Arbitration: a lone request wins outright; a tie goes to the pointer.
    assign req_any  = bus.REQ_UP | bus.REQ_DN;
    assign req_both = bus.REQ_UP & bus.REQ_DN;
    assign grant_up = req_both ? ptr_up_q : bus.REQ_UP;

    // State and control registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            drv_cnt    <= '0;
            turn_cnt   <= '0;
            sr_q       <= 1'b0;
            ptr_up_q   <= 1'b1;
            dir_last_q <= 1'b0;
            data_q     <= '0;
        end else begin
            state      <= state_nxt;
            drv_cnt    <= drv_cnt_nxt;
            turn_cnt   <= turn_cnt_nxt;
            sr_q       <= sr_nxt;
            ptr_up_q   <= ptr_up_nxt;
            dir_last_q <= dir_last_nxt;
            data_q     <= data_nxt;
        end
    end

    // Next-state logic. Counters default to zero so that every state entry
    // starts them cleared; they only advance while dwelling in their state.
    always_comb begin
        state_nxt    = state;
        drv_cnt_nxt  = '0;
        turn_cnt_nxt = '0;
        sr_nxt       = sr_q;
        ptr_up_nxt   = ptr_up_q;
        dir_last_nxt = dir_last_q;
        data_nxt     = data_q;
        arb_en       = 1'b0;

        case (state)
            ST_IDLE: begin
                arb_en = 1'b1;
            end

            ST_TURN: begin
                if (turn_cnt == TURN_LAST) begin
                    state_nxt = ST_DRIVE;
                end else begin
                    turn_cnt_nxt = turn_cnt + 3'd1;
                end
            end

            ST_DRIVE: begin
                if (drv_cnt == DRV_LAST) begin
                    state_nxt    = ST_DONE;
                    dir_last_nxt = sr_q;
                    data_nxt     = sr_q ? bus.BOUT_IN : bus.AOUT_IN;
                end else begin
                    drv_cnt_nxt = drv_cnt + 4'd1;
                end
            end

            ST_DONE: begin
                // The DONE exit edge is the return to IDLE; a request still
                // present here is granted at once so back-to-back transfers
                // see no extra idle cycle.
                state_nxt = ST_IDLE;
                arb_en    = 1'b1;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (arb_en && req_any) begin
            if (req_both) begin
                ptr_up_nxt = ~ptr_up_q;
            end
            if (grant_up == sr_q) begin
                state_nxt = ST_DRIVE;
            end else begin
                // SR moves with the TURN entry, so it is settled for the
                // whole dead gap before CE rises.
                state_nxt = ST_TURN;
                sr_nxt    = grant_up;
            end
        end
    end

    // Outputs are decoded from state only, so CE falls as soon as RST
    // clears the state register.
    assign bus.CE        = (state == ST_DRIVE);
    assign bus.SR        = sr_q;
    assign bus.BUSY      = (state != ST_IDLE);
    assign bus.DONE      = (state == ST_DONE);
    assign bus.DIR_LAST  = dir_last_q;
    assign bus.DATA_CAPT = data_q;

`ifdef BIDIR_XFER_CNT_EN
    logic [15:0] xfer_cnt;

    // Completed-transfer counter: counts DONE cycles, sticks at all-ones.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            xfer_cnt <= '0;
        end else if (bus.CNT_CLR) begin
            xfer_cnt <= '0;
        end else if ((state == ST_DONE) && (xfer_cnt != 16'hFFFF)) begin
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end

    assign bus.XFER_CNT = xfer_cnt;
`endif

endmodule

// File: tb/tb_bidir_buffer_ctrl.sv
`timescale 1ns/1ps
module tb_bidir_buffer_ctrl;

    localparam int D1 = 2;
    localparam int T1 = 1;
    localparam int D2 = 5;
    localparam int T2 = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bidir_buffer_ctrl_if bif ();
    bidir_buffer_ctrl_if bif2 ();

    bidir_buffer_ctrl #(.DRIVE_CYCLES(D1), .TURN_CYCLES(T1)) dut1 (
        .CLK (clk),
        .RST (rst),
        .bus (bif)
    );

    bidir_buffer_ctrl #(.DRIVE_CYCLES(D2), .TURN_CYCLES(T2)) dut2 (
        .CLK (clk),
        .RST (rst),
        .bus (bif2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level reference model for dut1: on a grant it lays out
    // the whole transfer as a list of per-cycle expectations.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic ce;
        logic sr;
        logic busy;
        logic done;
    } phase_t;

    phase_t     plan[$];
    phase_t     m_cur = '0;
    logic       m_sr  = 1'b0;
    logic       m_ptr = 1'b1;
    logic       m_dl  = 1'b0;
    logic [7:0] m_dc  = 8'h00;
    logic       m_dir;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                plan.delete();
                m_sr  = 1'b0;
                m_ptr = 1'b1;
                m_dl  = 1'b0;
                m_dc  = 8'h00;
                m_cur = '0;
            end else if (plan.size() > 0) begin
                m_cur = plan.pop_front();
                if (m_cur.done) begin
                    m_dl = m_sr;
                    m_dc = m_sr ? bif.BOUT_IN : bif.AOUT_IN;
                end
            end else if (bif.REQ_UP || bif.REQ_DN) begin
                m_dir = (bif.REQ_UP && bif.REQ_DN) ? m_ptr : bif.REQ_UP;
                if (bif.REQ_UP && bif.REQ_DN) m_ptr = ~m_ptr;
                if (m_dir != m_sr) begin
                    m_sr = m_dir;
                    repeat (T1) plan.push_back(phase_t'{1'b0, m_dir, 1'b1, 1'b0});
                end
                repeat (D1) plan.push_back(phase_t'{1'b1, m_dir, 1'b1, 1'b0});
                plan.push_back(phase_t'{1'b0, m_dir, 1'b1, 1'b1});
                m_cur = plan.pop_front();
            end else begin
                m_cur = phase_t'{1'b0, m_sr, 1'b0, 1'b0};
            end
        end
    end

    // Per-cycle monitor: model comparison plus the SR-stable-under-CE rule.
    logic mon_en  = 1'b0;
    logic prev_ce = 1'b0;
    logic prev_sr = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("model", 32'({bif.CE, bif.SR, bif.BUSY, bif.DONE, bif.DIR_LAST, bif.DATA_CAPT}),
                    32'({m_cur.ce, m_cur.sr, m_cur.busy, m_cur.done, m_dl, m_dc}));
                if (prev_ce && bif.CE) chk("sr_stable", 32'(bif.SR), 32'(prev_sr));
            end
            prev_ce = bif.CE;
            prev_sr = bif.SR;
        end
    end

    typedef struct {
        logic       up;
        logic       dn;
        logic [7:0] b;
        logic [7:0] a;
        logic       ce;
        logic       sr;
        logic       busy;
        logic       done;
        logic       dl;
        logic [7:0] dc;
    } vec_t;

    vec_t vt[11];

    task automatic wait_done(input int limit, output bit got);
        got = 1'b0;
        for (int i = 0; i < limit && !got; i++) begin
            @(negedge clk);
            if (bif.DONE) got = 1'b1;
        end
    endtask

    task automatic dn_xfer(input logic [7:0] a, output bit got);
        @(negedge clk);
        bif.AOUT_IN = a;
        bif.REQ_DN  = 1'b1;
        @(negedge clk);
        bif.REQ_DN  = 1'b0;
        wait_done(12, got);
    endtask

    bit         got;
    int         ndone;
    int         gap;
    bit         have_prev;
    logic       pce;
    logic       last_sr;
    int         low;
    int         high;
    int         done_at;
    int         sr_bad;
    bit         seen_ce;

    initial begin
        // {up, dn, BOUT, AOUT} -> {CE, SR, BUSY, DONE, DIR_LAST, DATA_CAPT}
        vt[0]  = '{1'b0, 1'b1, 8'h00, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vt[1]  = '{1'b0, 1'b0, 8'h00, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vt[2]  = '{1'b0, 1'b0, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A};
        vt[3]  = '{1'b1, 1'b0, 8'hC3, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A};
        vt[4]  = '{1'b1, 1'b0, 8'hC3, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A};
        vt[5]  = '{1'b1, 1'b0, 8'hC3, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A};
        vt[6]  = '{1'b1, 1'b0, 8'hC3, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hC3};
        vt[7]  = '{1'b1, 1'b0, 8'hC3, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hC3};
        vt[8]  = '{1'b0, 1'b0, 8'hC3, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hC3};
        vt[9]  = '{1'b0, 1'b0, 8'hC3, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hC3};
        vt[10] = '{1'b0, 1'b0, 8'hC3, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hC3};

        bif.REQ_UP   = 1'b0;
        bif.REQ_DN   = 1'b0;
        bif.BOUT_IN  = 8'h00;
        bif.AOUT_IN  = 8'h00;
        bif2.REQ_UP  = 1'b0;
        bif2.REQ_DN  = 1'b0;
        bif2.BOUT_IN = 8'h00;
        bif2.AOUT_IN = 8'h00;
`ifdef BIDIR_XFER_CNT_EN
        bif.CNT_CLR  = 1'b0;
        bif2.CNT_CLR = 1'b0;
`endif

        // Reset state
        @(negedge clk);
        chk("reset_state", 32'({bif.CE, bif.SR, bif.BUSY, bif.DONE, bif.DIR_LAST, bif.DATA_CAPT}), 32'h0);
        mon_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table: down pulse, up with turn, back-to-back up
        for (int i = 0; i < 11; i++) begin
            bif.REQ_UP  = vt[i].up;
            bif.REQ_DN  = vt[i].dn;
            bif.BOUT_IN = vt[i].b;
            bif.AOUT_IN = vt[i].a;
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                32'({bif.CE, bif.SR, bif.BUSY, bif.DONE, bif.DIR_LAST, bif.DATA_CAPT}),
                32'({vt[i].ce, vt[i].sr, vt[i].busy, vt[i].done, vt[i].dl, vt[i].dc}));
        end

        // Both requests held: grants alternate up/down with TURN gaps
        bif.REQ_UP = 1'b1;
        bif.REQ_DN = 1'b1;
        ndone = 0; gap = 0; have_prev = 1'b0; pce = bif.CE; last_sr = 1'b0;
        for (int c = 0; c < 60 && ndone < 4; c++) begin
            @(negedge clk);
            if (bif.CE && !pce) begin
                if (have_prev) chk("alt_gap", 32'(gap), (bif.SR != last_sr) ? 32'(T1) : 32'd0);
                last_sr   = bif.SR;
                have_prev = 1'b1;
                gap       = 0;
            end
            if (bif.BUSY && !bif.CE && !bif.DONE) gap++;
            if (bif.DONE) begin
                chk("alt_dir", 32'(bif.DIR_LAST), 32'(ndone % 2 == 0));
                ndone++;
                if (ndone == 4) begin
                    bif.REQ_UP = 1'b0;
                    bif.REQ_DN = 1'b0;
                end
            end
            pce = bif.CE;
        end
        bif.REQ_UP = 1'b0;
        bif.REQ_DN = 1'b0;
        chk("alt_count", 32'(ndone), 32'd4);
        @(negedge clk);

        // Reset in the second DRIVE cycle of an up transfer
        bif.BOUT_IN = 8'h77;
        bif.REQ_UP  = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (bif.CE) got = 1'b1;
        end
        chk("rst_ce_wait", 32'(got), 32'd1);
        bif.REQ_UP = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_pre_ce", 32'({bif.CE, bif.SR}), 32'b11);
        rst = 1'b1;
        #1;
        chk("rst_async", 32'({bif.CE, bif.SR, bif.BUSY, bif.DONE, bif.DATA_CAPT}), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (bif.DONE) ndone++;
        end
        chk("rst_no_done", 32'(ndone), 32'd0);
        dn_xfer(8'h3C, got);
        chk("post_rst_done", 32'(got), 32'd1);
        chk("post_rst_data", 32'({bif.DIR_LAST, bif.DATA_CAPT}), 32'({1'b0, 8'h3C}));

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            bif.REQ_UP  = ($urandom_range(0, 3) == 0);
            bif.REQ_DN  = ($urandom_range(0, 3) == 0);
            bif.BOUT_IN = 8'($urandom);
            bif.AOUT_IN = 8'($urandom);
        end
        bif.REQ_UP = 1'b0;
        bif.REQ_DN = 1'b0;
        repeat (12) @(negedge clk);

        // Second instance: DRIVE_CYCLES=5, TURN_CYCLES=3
        bif2.BOUT_IN = 8'hA5;
        bif2.AOUT_IN = 8'h96;
        bif2.REQ_UP  = 1'b1;
        @(negedge clk);
        bif2.REQ_UP  = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bif2.DONE) got = 1'b1;
        end
        chk("p_up_done", 32'(got), 32'd1);
        chk("p_up_data", 32'({bif2.DIR_LAST, bif2.DATA_CAPT}), 32'({1'b1, 8'hA5}));
        repeat (2) @(negedge clk);
        bif2.REQ_DN = 1'b1;
        @(negedge clk);
        bif2.REQ_DN = 1'b0;
        low = 0; high = 0; done_at = 0; sr_bad = 0; seen_ce = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) @(negedge clk);
            if (bif2.CE) begin
                seen_ce = 1'b1;
                high++;
                if (bif2.SR) sr_bad++;
            end else if (!seen_ce && bif2.BUSY) begin
                low++;
            end
            if (bif2.DONE && done_at == 0) done_at = k;
        end
        chk("p_turn_low", 32'(low), 32'(T2));
        chk("p_drive_high", 32'(high), 32'(D2));
        chk("p_done_at", 32'(done_at), 32'(T2 + D2 + 1));
        chk("p_sr_dn", 32'(sr_bad), 32'd0);
        chk("p_dn_data", 32'({bif2.DIR_LAST, bif2.DATA_CAPT}), 32'({1'b0, 8'h96}));

`ifdef BIDIR_XFER_CNT_EN
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("cnt_reset", 32'(bif.XFER_CNT), 32'h0);
        for (int i = 0; i < 3; i++) begin
            dn_xfer(8'(8'h10 + i), got);
            chk("cnt_xfer_done", 32'(got), 32'd1);
        end
        @(negedge clk);
        chk("cnt_three", 32'(bif.XFER_CNT), 32'd3);
        dn_xfer(8'h21, got);
        chk("cnt_clr_done", 32'(got), 32'd1);
        bif.CNT_CLR = 1'b1;
        @(negedge clk);
        bif.CNT_CLR = 1'b0;
        chk("cnt_clr_wins", 32'(bif.XFER_CNT), 32'h0);
        force dut1.xfer_cnt = 16'hFFFF;
        @(negedge clk);
        release dut1.xfer_cnt;
        dn_xfer(8'h22, got);
        chk("cnt_sat_done", 32'(got), 32'd1);
        @(negedge clk);
        chk("cnt_saturate", 32'(bif.XFER_CNT), 32'hFFFF);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
